// File: rtl/adder_arb.sv
// adder_arb: round-robin arbiter and sequencer that shares one 8-bit
// prefix adder (the adder5 datapath) among NREQ requesters.
// One operand pair is in flight at a time. The result and the requester
// ID come back on a single valid/ready response channel.
//
// Ports:
//   wb_clk_i   clock
//   wb_rst_i   asynchronous active-high reset
//   req_valid  per-requester request valid (NREQ)
//   req_a      packed operand A, requester i at [8i+7:8i]
//   req_b      packed operand B, same packing
//   req_ready  one-hot grant/accept strobe (combinational, IDLE only)
//   rsp_valid  response valid
//   rsp_ready  response accepted by the consumer
//   rsp_sum    (A+B) mod 256
//   rsp_id     index of the requester that issued the operation
//   rsp_carry  carry-out of the addition (only with ADDER_ARB_CARRY_EN)
//   busy       high whenever the FSM is not in IDLE
//
// Build option: define ADDER_ARB_CARRY_EN to add the rsp_carry port.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrate; on a winner latch its operands and ID
// EXEC  | operands drive the adder; capture sum and ID on the edge
// RESP  | hold the response until rsp_ready, then return to IDLE

module adder_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id,
`ifdef ADDER_ARB_CARRY_EN
  output logic              rsp_carry,
`endif
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [7:0]      op_a_q, op_a_d;
  logic [7:0]      op_b_q, op_b_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [IDW-1:0]  last_gnt_q, last_gnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
`ifdef ADDER_ARB_CARRY_EN
  logic            rsp_carry_q, rsp_carry_d;
`endif

  logic            gnt_found;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] req_ready_c;

  // adder5 datapath: 8-bit Kogge-Stone prefix adder, no carry-in.
  // Only the carries into bits 1..7 are built; the carry-out, when
  // wanted, is recovered by the (sum < a) compare instead.
  logic [7:0] adder5_a_in, adder5_b_in, adder5_sum;
  logic [7:0] p0;
  logic [6:0] g0, g1, g2, g3, p1, p2;

  assign adder5_a_in = op_a_q;
  assign adder5_b_in = op_b_q;

  always_comb begin
    p0 = adder5_a_in ^ adder5_b_in;
    g0 = adder5_a_in[6:0] & adder5_b_in[6:0];
    g1 = g0 | (p0[6:0] & {g0[5:0], 1'b0});
    p1 = p0[6:0] & {p0[5:0], 1'b1};
    g2 = g1 | (p1 & {g1[4:0], 2'b00});
    p2 = p1 & {p1[4:0], 2'b11};
    g3 = g2 | (p2 & {g2[2:0], 4'b0000});
    adder5_sum = p0 ^ {g3, 1'b0};
  end

  // Round-robin scan starting one past the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(last_gnt_q) + k) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cur_id_d    = cur_id_q;
    last_gnt_d  = last_gnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
`ifdef ADDER_ARB_CARRY_EN
    rsp_carry_d = rsp_carry_q;
`endif
    req_ready_c = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready_c[gnt_id] = 1'b1;
          op_a_d     = req_a[8*gnt_id +: 8];
          op_b_d     = req_b[8*gnt_id +: 8];
          cur_id_d   = gnt_id;
          last_gnt_d = gnt_id;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_sum_d   = adder5_sum;
        rsp_id_d    = cur_id_q;
        rsp_valid_d = 1'b1;
`ifdef ADDER_ARB_CARRY_EN
        rsp_carry_d = (adder5_sum < op_a_q);
`endif
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cur_id_q    <= '0;
      last_gnt_q  <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
`ifdef ADDER_ARB_CARRY_EN
      rsp_carry_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cur_id_q    <= cur_id_d;
      last_gnt_q  <= last_gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
`ifdef ADDER_ARB_CARRY_EN
      rsp_carry_q <= rsp_carry_d;
`endif
    end
  end

  // The grant is combinational from req_valid, so it is masked while reset
  // is held to keep every output at zero during reset.
  assign req_ready = wb_rst_i ? '0 : req_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
`ifdef ADDER_ARB_CARRY_EN
  assign rsp_carry = rsp_carry_q;
`endif
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/adder_arb.md
# adder_arb

Round-robin arbiter and sequencer that shares one `adder5` 8-bit prefix adder among `NREQ` requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes and registers the operands into the adder. It then captures the modulo-256 sum and returns it with the requester ID over a single valid/ready response channel. It sits between the user-project logic blocks and the adder instance inside the Caravel user area.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: width of the requester ID, equal to ceil(log2(NREQ)).

Ports:
- `wb_clk_i`  in  1: the single clock.
- `wb_rst_i`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: bit i is high when requester i has an operand pair.
- `req_a`  in  8*NREQ: operand A; bits [8i+7:8i] belong to requester i.
- `req_b`  in  8*NREQ: operand B, packed the same way as `req_a`.
- `req_ready`  out  NREQ: one-hot grant/accept strobe.
- `rsp_valid`  out  1: the result is valid.
- `rsp_ready`  in  1: the consumer accepts the result.
- `rsp_sum`  out  8: (A+B) mod 256.
- `rsp_id`  out  IDW: index of the requester that issued the operation.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `rsp_carry`  out  1: carry-out of the addition. Present only with `ADDER_ARB_CARRY_EN`.

## Operation
- The FSM has three states, IDLE, EXEC and RESP, encoded in 2 bits.
- **IDLE:**
  - Scan `req_valid` starting at `last_gnt+1` and wrapping modulo NREQ. The first set bit wins.
  - Drive `req_ready` one-hot and combinationally for the winner only.
  - On the clock edge, latch that requester's operands into `op_a`/`op_b` and its index into `cur_id`. Set `last_gnt` to the winner and go to EXEC.
  - If no request is present, `req_ready` is 0 and the FSM stays in IDLE.
- **EXEC:**
  - `op_a`/`op_b` drive the `adder5` `a_in`/`b_in` inputs directly.
  - On the edge, capture `sum` into `rsp_sum` and `cur_id` into `rsp_id`. Set `rsp_valid` and go to RESP.
- **RESP:**
  - Hold `rsp_valid`, `rsp_sum`, `rsp_id` (and `rsp_carry` when built in) stable.
  - When `rsp_ready` is 1, clear `rsp_valid` on the edge and go to IDLE.
  - There is no timeout.
- `req_ready` is 0 in EXEC and RESP. New requests are never accepted while a result is pending, so there is exactly one operation in flight.
- Requesters must hold `req_valid`, `req_a` and `req_b` until they see `req_ready`. Deasserting a request without a grant is allowed and has no side effects.
- Arithmetic:
  - 8-bit unsigned, wrap-around. There is no carry-in.
  - The adder carry-out is not used unless `ADDER_ARB_CARRY_EN` is defined.
- Fairness: a continuously requesting requester is granted at most once before every other continuously requesting requester has been granted.

## Timing
- Reset values:
  - FSM = IDLE.
  - `req_ready`, `rsp_valid`, `rsp_sum`, `rsp_id`, `busy`, `rsp_carry` = 0.
  - `op_a`, `op_b`, `cur_id` = 0.
  - `last_gnt` = NREQ-1, so requester 0 wins the first arbitration.
- Reset is asynchronous and takes effect immediately, including mid-EXEC or mid-RESP. Any pending result is discarded and not re-issued.
- Latency, with acceptance at edge k:
  - `rsp_valid` is high after edge k+1.
  - The earliest next acceptance is at edge k+3, given `rsp_ready`=1 in the first RESP cycle.
- Peak throughput is one operation per 3 cycles. Each additional cycle with `rsp_ready`=0 adds one cycle.
- The adder path is purely combinational for one cycle, register to register. No multicycle constraint is needed.
- `rsp_ready` sampled high in IDLE or EXEC has no effect.

## Configuration
- `ADDER_ARB_CARRY_EN` defined:
  - Port `rsp_carry` exists.
  - It is registered together with `rsp_sum` as (`sum` < `op_a`), which is the unsigned carry-out.
  - It follows the same hold and reset rules as `rsp_sum`.
- `ADDER_ARB_CARRY_EN` undefined:
  - There is no `rsp_carry` port and no comparator logic.
  - All other behaviour is identical.

## Test plan
- **Single request:** after reset, requester 2 sends A=0x12, B=0x34 with `rsp_ready`=1.
  - `req_ready`=4'b0100 for one cycle.
  - One cycle later, `rsp_valid`=1 with `rsp_sum`=0x46 and `rsp_id`=2.
  - `busy` is high for exactly 2 cycles.
- **Round-robin:** all 4 requesters hold valid, with A=i and B=0x10.
  - Grant order is 0,1,2,3,0.
  - `rsp_sum` sequence is 0x10, 0x11, 0x12, 0x13.
  - Acceptances occur every 3 cycles.
- **Wrap and carry:** A=0xFF, B=0x01 gives `rsp_sum`=0x00. With `ADDER_ARB_CARRY_EN`, `rsp_carry`=1.
  - A=0x80, B=0x80 gives `rsp_sum`=0x00 and `rsp_carry`=1.
  - A=0x7F, B=0x01 gives `rsp_sum`=0x80 and `rsp_carry`=0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles while requesters 0 and 1 are pending.
  - `rsp_valid`, `rsp_sum` and `rsp_id` stay stable.
  - `req_ready`=0 throughout.
  - Requester 1 is granted on the first IDLE cycle after `rsp_ready` is raised.
- **Reset mid-operation:** assert `wb_rst_i` in EXEC, and again in a separate run in RESP.
  - All outputs go to 0 immediately.
  - After release, with requesters 1 and 3 pending, requester 1 is granted first, since the pointer has been reset.
- **Withdrawn request:** requester 3 raises valid for one cycle while the FSM is in RESP, then drops it.
  - No grant is given to requester 3.
  - No response is produced for it.
